range_frame_sender: RTL
=======================

Name: range_frame_sender

Overview:
- Transmit end of the go/finish framed sample protocol that the range-tracking block consumes.
- Buffers incoming samples in an internal circular FIFO via valid/ready.
- On a start command, emits one contiguous frame of `len` samples: `go` on the first word, `finish` on the last word, data on every cycle of the frame.
- Sits between a sample source (testbench or ADC capture) and the range tracker; drives the tracker's `data_in`, `go` and `finish` directly.

Parameters:
- WIDTH, 16, sample width in bits.
- DEPTH, 8, FIFO capacity in words; must be a power of two, at least 2.
- LENW, $clog2(DEPTH+1), width of the length and count fields.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  sample to enqueue.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a word; equals !full.
- start  input  1  request to send one frame.
- len  input  LENW  frame length in words; sampled with start.
- start_ready  output  1  high only in IDLE.
- busy  output  1  high in ARM or SEND.
- data_out  output  WIDTH  frame word (FIFO head) during SEND; 0 otherwise.
- go  output  1  first word of frame.
- finish  output  1  last word of frame.
- done  output  1  one-cycle pulse the cycle after finish.
- cmd_error  output  1  one-cycle pulse: start rejected.
- fifo_count  output  LENW  words currently held, 0..DEPTH.

Behaviour:
- Reset (async, any state):
  - FIFO empty, read/write pointers 0, fifo_count=0.
  - State IDLE.
  - go=finish=done=cmd_error=0, data_out=0, busy=0, start_ready=1, in_ready=1.
  - Reset mid-frame aborts the frame immediately; no finish or done is produced.
- FIFO:
  - Push occurs when in_valid && in_ready at the clock edge.
  - Pop occurs on every SEND cycle.
  - Push and pop in the same cycle: count unchanged.
  - A push when full is impossible because in_ready=0.
  - Pointers wrap modulo DEPTH.
- IDLE:
  - start with 2<=len<=DEPTH: latch len into the remaining counter, go to ARM.
  - start with len<2 or len>DEPTH: pulse cmd_error the next cycle, stay IDLE.
  - len<2 is rejected because go and finish must never be high together.
- ARM:
  - Wait until fifo_count >= remaining, then enter SEND on the next edge.
  - start is ignored while not in IDLE.
- SEND:
  - Every cycle, data_out = FIFO head (combinational from storage), pop, decrement remaining.
  - go=1 only on the first SEND cycle.
  - finish=1 only when remaining==1.
  - A frame of len N therefore spans exactly N consecutive cycles: go at cycle 0, finish at cycle N-1.
  - After the finish edge, go to IDLE and set done=1 for exactly one cycle.
  - A new start may be accepted in that same done cycle.
- Frame integrity:
  - Frames are contiguous by construction; ARM guarantees that all words are present before go.
  - Pushes during SEND are allowed and do not alter the frame in progress.
- Latency: with data already buffered, go rises 2 cycles after the start edge (IDLE→ARM→SEND).
- Outputs go, finish, data_out and done are driven only from state and registers; there is no combinational path from start or in_valid.

Test Plan:
- Reset, push 5,9,2,7; start len=4 → go with data_out=5; then 9, 2; finish with 7; done next cycle; fifo_count=0; tracker range=7.
- start len=3 with FIFO empty, then push 1,2,3 one per cycle → busy, no go until the 3rd word is stored; frame 1,2,3 contiguous with go/finish on the ends.
- start len=1 and start len=DEPTH+1 → cmd_error pulses, state stays IDLE, FIFO untouched.
- Fill FIFO to DEPTH=8 → in_ready=0, fifo_count=8; send len=8 while pushing new words → pointer wrap correct, second frame data in order.
- Assert reset during the 2nd word of a len=4 frame → go/finish/data_out=0 immediately, fifo_count=0, start_ready=1, no done.
- Back-to-back: start len=2 accepted in the done cycle of the prior frame → next go exactly 2 cycles later; go and finish never high simultaneously.

Source files
------------

// File: rtl/range_frame_sender.sv
// Transmit side of the go/finish framed sample protocol: buffers samples in a
// circular FIFO and, on a start command, emits one contiguous frame of len words.
module range_frame_sender #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int LENW  = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             start,
    input  logic [LENW-1:0]  len,
    output logic             start_ready,
    output logic             busy,
    output logic [WIDTH-1:0] data_out,
    output logic             go,
    output logic             finish,
    output logic             done,
    output logic             cmd_error,
    output logic [LENW-1:0]  fifo_count
);

    localparam int PTRW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        SEND
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LENW-1:0]  count_q, count_d;
    logic [LENW-1:0]  remaining_q, remaining_d;
    logic             first_q, first_d;
    logic             done_q, done_d;
    logic             cmd_error_q, cmd_error_d;
    logic             push;
    logic             pop;
    logic             len_ok;

    assign in_ready = (count_q != LENW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == SEND);
    // A one-word frame would need go and finish together, so it is refused.
    assign len_ok   = (len >= LENW'(2)) && (len <= LENW'(DEPTH));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTRW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + LENW'(1);
        end else if (!push && pop) begin
            count_d = count_q - LENW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        first_d     = 1'b0;
        done_d      = 1'b0;
        cmd_error_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        remaining_d = len;
                        state_d     = ARM;
                    end else begin
                        cmd_error_d = 1'b1;
                    end
                end
            end
            ARM: begin
                // Waiting for the whole frame keeps SEND free of gaps.
                if (count_q >= remaining_q) begin
                    state_d = SEND;
                    first_d = 1'b1;
                end
            end
            SEND: begin
                remaining_d = remaining_q - LENW'(1);
                if (remaining_q == LENW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            first_q     <= 1'b0;
            done_q      <= 1'b0;
            cmd_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            done_q      <= done_d;
            cmd_error_q <= cmd_error_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign data_out    = (state_q == SEND) ? mem_q[rd_ptr_q] : '0;
    assign go          = (state_q == SEND) && first_q;
    assign finish      = (state_q == SEND) && (remaining_q == LENW'(1));
    assign done        = done_q;
    assign cmd_error   = cmd_error_q;
    assign busy        = (state_q != IDLE);
    assign start_ready = (state_q == IDLE);
    assign fifo_count  = count_q;

endmodule
